// File: rtl/dlx_alu_pkg.sv
// rtl/dlx_alu_pkg.sv - op codes, FSM states and op classification for dlx_alu_mc (DLX_ALU_DIV_EN)
package dlx_alu_pkg;

  typedef enum logic [4:0] {
    ALU_LHI    = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_AND    = 5'd3,
    ALU_OR     = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SLL    = 5'd6,
    ALU_SRL    = 5'd7,
    ALU_SELZ   = 5'd8,
    ALU_SELNZ  = 5'd9,
    ALU_SEQ    = 5'd10,
    ALU_SLE    = 5'd11,
    ALU_SLT    = 5'd12,
    ALU_SNE    = 5'd13,
    ALU_SRA    = 5'd14,
    ALU_ADD4   = 5'd15,
    ALU_SELZ4  = 5'd16,
    ALU_SELNZ4 = 5'd17,
    ALU_SLEU   = 5'd18,
    ALU_SLTU   = 5'd19,
    ALU_MUL    = 5'd20,
    ALU_MULHU  = 5'd21,
    ALU_DIVU   = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

  // Without the divider, DIVU/REMU fall back to the single-cycle illegal path.
  function automatic logic is_multicycle(alu_op_e op);
`ifdef DLX_ALU_DIV_EN
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
    return (op == ALU_MUL) || (op == ALU_MULHU);
`endif
  endfunction

endpackage

// File: rtl/dlx_muldiv_iter.sv
// rtl/dlx_muldiv_iter.sv - iterative shift-add multiplier / restoring divider (divider under DLX_ALU_DIV_EN)
module dlx_muldiv_iter
  import dlx_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic             busy;
  logic             is_div;
  logic             dz_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   add_sum;

  assign add_sum = {1'b0, acc} + {1'b0, b_q};

`ifdef DLX_ALU_DIV_EN
  logic [WIDTH:0] trial;
  logic [WIDTH:0] trial_sub;
  logic           take;

  assign trial     = {acc, sr[WIDTH-1]};
  assign trial_sub = trial - {1'b0, b_q};
  assign take      = (trial >= {1'b0, b_q});
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      is_div <= 1'b0;
      dz_q   <= 1'b0;
      acc    <= '0;
      sr     <= '0;
      b_q    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(WIDTH);
      is_div <= (op == ALU_DIVU) || (op == ALU_REMU);
      dz_q   <= ((op == ALU_DIVU) || (op == ALU_REMU)) && (b == '0);
      acc    <= '0;
      sr     <= a;
      b_q    <= b;
    end else if (busy) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        // acc/sr hold {hi,lo} for multiply and {remainder,quotient} for divide
        if (is_div) begin
`ifdef DLX_ALU_DIV_EN
          acc <= take ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
          sr  <= {sr[WIDTH-2:0], take};
`endif
        end else if (sr[0]) begin
          {acc, sr} <= {add_sum, sr[WIDTH-1:1]};
        end else begin
          {acc, sr} <= {1'b0, acc, sr[WIDTH-1:1]};
        end
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done = busy && (cnt == '0);
  assign lo   = sr;
  assign hi   = acc;
  assign dz   = dz_q;

endmodule

// File: rtl/dlx_alu_mc.sv
// rtl/dlx_alu_mc.sv - multi-cycle DLX execute ALU top; DLX_ALU_DIV_EN enables DIVU/REMU
module dlx_alu_mc
  import dlx_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             ovf,
  output logic             z,
  output logic             dz
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_state_e       state;
  alu_op_e          op_q;
  logic             multi;
  logic             md_start;
  logic             md_done;
  logic             md_dz;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_res;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic             sc_ovf;

  function automatic logic [WIDTH-1:0] zx(input logic bit_in);
    return {{(WIDTH-1){1'b0}}, bit_in};
  endfunction

  assign multi    = is_multicycle(alu_op_e'(op));
  assign in_ready = (state == IDLE);
  assign md_start = in_valid && in_ready && multi;
  assign sum      = {1'b0, op1} + {1'b0, op2};
  assign dif      = {1'b0, op1} - {1'b0, op2};
  assign sh       = op2[SHW-1:0];
  assign md_res   = ((op_q == ALU_MUL) || (op_q == ALU_DIVU)) ? md_lo : md_hi;

  dlx_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (op),
    .a     (op1),
    .b     (op2),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi),
    .dz    (md_dz)
  );

  // Multi-cycle and unassigned codes land in default and produce zero.
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (alu_op_e'(op))
      ALU_LHI:    sc_res = op2 << (WIDTH / 2);
      ALU_ADD: begin
        {sc_carry, sc_res} = sum;
        sc_ovf = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]);
      end
      ALU_SUB: begin
        {sc_carry, sc_res} = dif;
        sc_ovf = (op1[MSB] != op2[MSB]) && (dif[MSB] != op1[MSB]);
      end
      ALU_AND:    sc_res = op1 & op2;
      ALU_OR:     sc_res = op1 | op2;
      ALU_XOR:    sc_res = op1 ^ op2;
      ALU_SLL:    sc_res = op1 << sh;
      ALU_SRL:    sc_res = op1 >> sh;
      ALU_SRA:    sc_res = WIDTH'($signed(op1) >>> sh);
      ALU_SELZ:   sc_res = (op1 == '0) ? op2 : '0;
      ALU_SELNZ:  sc_res = (op1 != '0) ? op2 : '0;
      ALU_SEQ:    sc_res = zx(op1 == op2);
      ALU_SNE:    sc_res = zx(op1 != op2);
      ALU_SLE:    sc_res = zx($signed(op1) <= $signed(op2));
      ALU_SLT:    sc_res = zx($signed(op1) < $signed(op2));
      ALU_ADD4:   sc_res = op1 + WIDTH'(4);
      ALU_SELZ4:  sc_res = (op1 == '0) ? op2 : WIDTH'(4);
      ALU_SELNZ4: sc_res = (op1 != '0) ? op2 : WIDTH'(4);
      ALU_SLEU:   sc_res = zx(op1 <= op2);
      ALU_SLTU:   sc_res = zx(op1 < op2);
      default:    sc_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= ALU_LHI;
      res       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      z         <= 1'b0;
      dz        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (multi) begin
              state <= BUSY;
              op_q  <= alu_op_e'(op);
            end else begin
              res       <= sc_res;
              carry     <= sc_carry;
              ovf       <= sc_ovf;
              z         <= (sc_res == '0);
              dz        <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (md_done) begin
            res       <= md_res;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            z         <= (md_res == '0);
            dz        <= md_dz;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_alu_mc.sv
// tb/tb_dlx_alu_mc.sv - self-checking bench for dlx_alu_mc (honours DLX_ALU_DIV_EN)
module tb_dlx_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        out_valid;
  logic [31:0] res;
  logic        carry;
  logic        ovf;
  logic        z;
  logic        dz;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dlx_alu_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .res       (res),
    .carry     (carry),
    .ovf       (ovf),
    .z         (z),
    .dz        (dz)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: lat counts posedges after the accepting edge until out_valid is seen.
  task automatic model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic c, output logic v,
                       output logic d, output int lat);
    logic [63:0] p;
    int unsigned s;
    r = 32'h0; c = 1'b0; v = 1'b0; d = 1'b0; lat = 0;
    s = b % 32;
    case (o)
      5'd0:  r = b << 16;
      5'd1: begin
        p = 64'(a) + 64'(b);
        r = p[31:0]; c = p[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'd2: begin
        r = a - b; c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'd3:  r = a & b;
      5'd4:  r = a | b;
      5'd5:  r = a ^ b;
      5'd6:  r = a << s;
      5'd7:  r = a >> s;
      5'd14: r = 32'($signed(a) >>> s);
      5'd8:  r = (a == 0) ? b : 32'd0;
      5'd9:  r = (a != 0) ? b : 32'd0;
      5'd10: r = (a == b) ? 32'd1 : 32'd0;
      5'd13: r = (a != b) ? 32'd1 : 32'd0;
      5'd11: r = ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      5'd12: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd15: r = a + 32'd4;
      5'd16: r = (a == 0) ? b : 32'd4;
      5'd17: r = (a != 0) ? b : 32'd4;
      5'd18: r = (a <= b) ? 32'd1 : 32'd0;
      5'd19: r = (a < b) ? 32'd1 : 32'd0;
      5'd20: begin p = 64'(a) * 64'(b); r = p[31:0];  lat = 33; end
      5'd21: begin p = 64'(a) * 64'(b); r = p[63:32]; lat = 33; end
`ifdef DLX_ALU_DIV_EN
      5'd22: begin
        lat = 33;
        if (b == 0) begin r = 32'hFFFF_FFFF; d = 1'b1; end
        else r = a / b;
      end
      5'd23: begin
        lat = 33;
        if (b == 0) begin r = a; d = 1'b1; end
        else r = a % b;
      end
`endif
      default: r = 32'h0;
    endcase
  endtask

  // Called at a negedge with the unit idle; returns at the negedge where out_valid is seen.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ec, ev, ed;
    int          elat, lat;
    bit          leak;
    model(o, a, b, er, ec, ev, ed, elat);
    chk({tag, " ready_before"}, in_ready, 1);
    in_valid = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = 5'($urandom); op1 = $urandom; op2 = $urandom;
    lat = 0; leak = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " res"}, res, er);
    chk({tag, " carry"}, carry, ec);
    chk({tag, " ovf"}, ovf, ev);
    chk({tag, " z"}, z, (er == 0));
    chk({tag, " dz"}, dz, ed);
    chk({tag, " ready_at_done"}, in_ready, 1);
    if (elat > 0) chk({tag, " ready_low_busy"}, leak, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] xa [3];
    logic [31:0] xb [3];
    bit seen;

    rst = 1'b1; in_valid = 1'b0; op = 5'd0; op1 = 32'h0; op2 = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst res", res, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst flags", {carry, ovf, z, dz}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_wrap", 5'd1, 32'hFFFF_FFFF, 32'h1);
    run_op("add_ovf", 5'd1, 32'h7FFF_FFFF, 32'h1);
    run_op("sub_borrow", 5'd2, 32'h0, 32'h1);
    run_op("sub_ovf", 5'd2, 32'h8000_0000, 32'h1);
    run_op("slt", 5'd12, 32'hFFFF_FFFF, 32'h1);
    run_op("sltu", 5'd19, 32'hFFFF_FFFF, 32'h1);
    run_op("sra", 5'd14, 32'h8000_0000, 32'd31);
    run_op("sll_mask", 5'd6, 32'h1, 32'h25);
    run_op("lhi", 5'd0, 32'h0, 32'h0000_ABCD);
    run_op("mulhu", 5'd21, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("add_after_mul", 5'd1, 32'd5, 32'd6);
    run_op("mul", 5'd20, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("divu_zero", 5'd22, 32'd100, 32'd0);
    run_op("remu_7", 5'd23, 32'd100, 32'd7);
    run_op("remu_zero", 5'd23, 32'd100, 32'd0);
    run_op("illegal_24", 5'd24, 32'h5, 32'h6);
    run_op("illegal_31", 5'd31, 32'hFFFF_FFFF, 32'h1);

    for (int i = 0; i < 150; i++) begin
      run_op("rand", 5'($urandom_range(0, 31)), pick(), pick());
    end

    for (int i = 0; i < 3; i++) begin
      xa[i] = $urandom; xb[i] = $urandom;
    end
    in_valid = 1'b1; op = 5'd5; op1 = xa[0]; op2 = xb[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b out_valid", out_valid, 1);
      chk("b2b res", res, xa[i] ^ xb[i]);
      if (i < 2) begin
        op1 = xa[i+1]; op2 = xb[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b pulse_end", out_valid, 0);
    chk("b2b hold", res, xa[2] ^ xb[2]);

    in_valid = 1'b1; op = 5'd20; op1 = 32'hDEAD_BEEF; op2 = 32'h0000_1235;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst busy", in_ready, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst res", res, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst no_out_valid", seen, 0);
    run_op("post_rst_mul", 5'd20, 32'd7, 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dlx_alu_mc.md
Name: dlx_alu_mc

Overview:
- Parametrised, multi-cycle successor to the DLX execute-stage ALU.
- Keeps the single-cycle operation set, with two changes:
  - shift amount widened to the full log2(WIDTH);
  - signed compare variants added.
- Adds an iterative unsigned multiply/divide unit behind a valid/ready handshake.
- Sits in the EX stage. The pipeline controller stalls on in_ready=0.

Parameters:
- WIDTH, 32, datapath width in bits; power of two, ≥8.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- op  in  5  operation code (alu_op_e)
- op1  in  WIDTH  operand 1
- op2  in  WIDTH  operand 2
- out_valid  out  1  one-cycle pulse: res/flags are new
- res  out  WIDTH  result
- carry  out  1  carry/borrow out (ADD/SUB only, else 0)
- ovf  out  1  signed overflow (ADD/SUB only, else 0)
- z  out  1  res == 0
- dz  out  1  divide by zero (DIVU/REMU only, else 0)

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, res=0, carry=0, ovf=0, z=0, dz=0, out_valid=0, in_ready=1.
  - Any in-flight multi-cycle op is discarded and produces no out_valid.
- Accept: a request is taken on a posedge with in_valid & in_ready.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0.
- Single-cycle ops (0–19):
  - Accepted in IDLE; registered result with out_valid=1 on the next posedge.
  - Stays in IDLE, so back-to-back acceptance is allowed every cycle.
- Op codes:
  - 0 LHI: op2<<(WIDTH/2).
  - 1 ADD: {carry,res}=op1+op2.
  - 2 SUB: {carry,res}=op1-op2; carry is the borrow.
  - 3 AND, 4 OR, 5 XOR.
  - 6 SLL, 7 SRL, 14 SRA: shift by op2[SHW-1:0].
  - 8: res = (op1==0) ? op2 : 0.
  - 9: res = (op1!=0) ? op2 : 0.
  - 10 SEQ, 13 SNE.
  - 11 SLE, 12 SLT: signed.
  - 15: op1+4.
  - 16: res = (op1==0) ? op2 : 4.
  - 17: res = (op1!=0) ? op2 : 4.
  - 18 SLEU, 19 SLTU: unsigned.
  - Set ops return 1 or 0, zero-extended to WIDTH.
- Multi-cycle ops:
  - 20 MUL: low WIDTH bits of product.
  - 21 MULHU: high WIDTH bits.
  - 22 DIVU: quotient.
  - 23 REMU: remainder.
  - Acceptance moves IDLE→BUSY and loads the operands plus an iteration counter = WIDTH.
  - One shift-add or restoring-subtract step per cycle.
  - Counter reaching 0 → results registered, out_valid=1, BUSY→IDLE.
  - Latency: exactly WIDTH+1 cycles from the accepting edge to the out_valid edge.
  - in_ready returns to 1 in the same cycle out_valid=1.
- Divide by zero (op2==0):
  - Counter is still honoured, so the latency is identical.
  - DIVU: res=all-ones. REMU: res=op1. Both set dz=1.
- Codes 24–31: single-cycle; res=0, z=1, all other flags 0.
- ovf is set for ADD when both operands have the same sign and the result sign differs. For SUB it is set when the operands differ in sign and the result sign differs from op1.
- Hold behaviour:
  - res and flags hold their values between out_valid pulses.
  - No backpressure on the output side.
  - in_valid while BUSY is ignored; the requester must hold it.

Optional Feature:
- Macro: DLX_ALU_DIV_EN.
- Defined: DIVU/REMU are built as above.
- Undefined:
  - No divider hardware.
  - Ops 22/23 are treated as single-cycle illegal codes: res=0, z=1, dz=0, next-cycle out_valid.
  - MUL/MULHU are unaffected.

Decomposition:
- Package dlx_alu_pkg:
  - typedef enum logic[4:0] alu_op_e with all codes above.
  - FSM typedef alu_state_e {IDLE, BUSY}.
  - Function is_multicycle(alu_op_e).
- Sub-module dlx_muldiv_iter:
  - Owns the counter, accumulator and quotient/remainder shift registers.
  - Interface: start/op/a/b in; done/lo/hi/dz out.
- Top-level: single-cycle datapath, flag logic and handshake FSM.

Test Plan:
- WIDTH=32, ADD op1=0xFFFFFFFF, op2=1 → next cycle res=0, carry=1, z=1, ovf=0, out_valid=1.
- ADD op1=0x7FFFFFFF, op2=1 → res=0x80000000, ovf=1, carry=0. SLT op1=0xFFFFFFFF, op2=1 → res=1; SLTU with the same operands → res=0.
- SRA op1=0x80000000, op2=31 → res=0xFFFFFFFF. SLL op1=1, op2=0x25 → res=0x20, since only op2[4:0] is used.
- MULHU op1=op2=0xFFFFFFFF → in_ready=0 for 32 cycles, out_valid on cycle 33, res=0xFFFFFFFE. A new ADD is accepted that same cycle.
- DIVU 100/0 (DLX_ALU_DIV_EN) → res=0xFFFFFFFF, dz=1, latency 33. REMU 100/7 → res=2, dz=0.
- MUL in flight, rst pulsed at cycle 10 → no out_valid, in_ready=1 and res=0 after the reset edge. Back-to-back XOR requests on 3 consecutive cycles → 3 consecutive out_valid pulses.
